// File: rtl/shared_port_arbiter_if.sv
// Shared-port arbitration bundle: requests in, grant/select/status out.
interface shared_port_arbiter_if;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] choose;
  logic       busy;
  logic       preempt;

  modport master (
    output req,
    input  grant,
    input  choose,
    input  busy,
    input  preempt
  );

  modport slave (
    input  req,
    output grant,
    output choose,
    output busy,
    output preempt
  );
endinterface

// File: rtl/shared_port_arbiter.sv
// 4-way round-robin owner arbiter for a shared datapath port,
// with a hold limit that pre-empts the owner only under contention.
module shared_port_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  shared_port_arbiter_if.slave bus
);

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE,
    OWNED
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] rr_q, rr_d;
  logic [7:0] hold_q, hold_d;
  logic       pre_q, pre_d;

  logic [1:0] pick;
  logic       found;
  logic [3:0] others;
  logic       own_req;
  logic       sat;
  logic       do_rel;
  logic       do_pre;
  logic       do_keep;

  always_comb begin
    pick  = rr_q;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!found && bus.req[rr_q + 2'(k)]) begin
        pick  = rr_q + 2'(k);
        found = 1'b1;
      end
    end
  end

  assign others  = bus.req & ~(4'b0001 << owner_q);
  assign own_req = bus.req[owner_q];
  assign sat     = (hold_q == HOLD_LIM);
  // Owner dropping its request wins over a coincident hold-limit hit.
  assign do_rel  = !own_req;
  assign do_pre  = own_req && sat && (|others);
  assign do_keep = own_req && !(sat && (|others));

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    hold_d  = hold_q;
    pre_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = OWNED;
          owner_d = pick;
          hold_d  = 8'd0;
        end
      end
      OWNED: begin
        unique case (1'b1)
          do_rel: begin
            state_d = IDLE;
            rr_d    = owner_q + 2'd1;
          end
          do_pre: begin
            state_d = IDLE;
            rr_d    = owner_q + 2'd1;
            pre_d   = 1'b1;
          end
          do_keep: begin
            if (!sat) hold_d = hold_q + 8'd1;
          end
          default: ;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      rr_q    <= 2'd0;
      hold_q  <= 8'd0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
      pre_q   <= pre_d;
    end
  end

  assign bus.busy    = (state_q == OWNED);
  assign bus.grant   = bus.busy ? (4'b0001 << owner_q) : 4'b0000;
  assign bus.choose  = owner_q;
  assign bus.preempt = pre_q;

endmodule

// File: doc/shared_port_arbiter.md
SHARED_PORT_ARBITER -- requirements
Module: shared_port_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8: the maximum number of consecutive grant cycles before the owner is pre-empted, if another requester is waiting. Legal range is 2..255.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port req, input, 4 bits: req[i] high means requester i wants the shared 4:1 datapath port.
REQ-005 Port grant, output, 4 bits: one-hot or zero; grant[i] high means requester i owns the port.
REQ-006 Port choose, output, 2 bits: select code for the shared 4:1 multiplexer; value i routes requester i.
REQ-007 Port busy, output, 1 bit: high while any grant bit is high.
REQ-008 Port preempt, output, 1 bit: one-cycle pulse marking a forced release by the hold limit.

Function
REQ-009 The block SHALL implement two states, IDLE and OWNED, with a registered owner index (2 bits), a round-robin pointer rr_ptr (2 bits) and a hold counter hold_cnt (8 bits).
REQ-010 In IDLE, when req is non-zero, the block SHALL select the first i with req[i]=1 searching rr_ptr, rr_ptr+1, ... (mod 4), load owner=i, clear hold_cnt, and enter OWNED on that edge.
REQ-011 Grant latency SHALL be exactly 1 cycle: req sampled high in IDLE gives grant on the following cycle.
REQ-012 All outputs SHALL be registered or decoded only from registered state; there are no combinational paths from req to grant, choose, busy or preempt.
REQ-013 In OWNED, grant SHALL be one-hot at owner, busy=1, and choose=owner.
REQ-014 In OWNED, hold_cnt SHALL increment by 1 every cycle and saturate at MAX_HOLD-1.
REQ-015 In OWNED, if req[owner]=0, the block SHALL return to IDLE on that edge and set rr_ptr=owner+1 mod 4. This is a normal release; preempt stays 0.
REQ-016 In OWNED, if req[owner]=1 and hold_cnt=MAX_HOLD-1 and any other req bit is 1, the block SHALL return to IDLE, set rr_ptr=owner+1 mod 4, and pulse preempt for the following cycle.
REQ-017 In OWNED, if hold_cnt=MAX_HOLD-1 and no other request is pending, the owner SHALL keep the grant indefinitely; pre-emption is evaluated every cycle from then on.
REQ-018 Every release SHALL pass through exactly one IDLE cycle with grant=0 and busy=0 (one bubble cycle) before the next grant.
REQ-019 In IDLE, choose SHALL hold the last owner value so the datapath select does not toggle spuriously.
REQ-020 rr_ptr SHALL change only on a release, with wrap-around 3 -> 0.
REQ-021 A pre-empted requester that keeps req high SHALL be re-arbitrated normally and has lowest priority relative to rr_ptr.
REQ-022 Any waiting requester SHALL receive a grant within 4*(MAX_HOLD+1) cycles (starvation freedom).
REQ-023 If req[owner] falls in the same cycle the hold limit is reached, normal release (REQ-015) SHALL take precedence and preempt SHALL stay 0.
REQ-024 When req is all zeros in IDLE, the block SHALL stay in IDLE with all state unchanged.

Reset
REQ-025 While rst_n=0, the block SHALL immediately hold: state=IDLE, owner=0, rr_ptr=0, hold_cnt=0, grant=4'b0000, choose=2'b00, busy=0, preempt=0.
REQ-026 Reset asserted mid-grant SHALL drop grant asynchronously without a preempt pulse.
REQ-027 After rst_n rises, the first arbitration SHALL use rr_ptr=0.

Verification
REQ-028 Single requester: req=4'b0100 from reset -> grant=4'b0100 and choose=2'b10 one cycle later; req drops -> grant=0 next cycle, busy=0.
REQ-029 Round-robin: req=4'b1111 held, MAX_HOLD=8 -> grant order 0,1,2,3,0, each grant 8 cycles, preempt pulse after each, one bubble cycle between grants.
REQ-030 Hold limit with no contention: req=4'b0001 held for 20 cycles -> grant stays 4'b0001 throughout, preempt never asserted.
REQ-031 Simultaneous events: owner drops req in the cycle hold_cnt=MAX_HOLD-1 while req[2]=1 -> preempt=0, rr_ptr advances, requester 2 is granted after one bubble.
REQ-032 Reset mid-grant: rst_n low while grant=4'b1000 -> grant=0, choose=2'b00 asynchronously; after release with req=4'b1010, requester 1 is granted first.
